alu_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide companion to the single-cycle EX-stage ALU in the MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall toward the hazard unit while a result is pending; supports pipeline flush.

---
 rtl/alu_muldiv.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, MFHI/MFLO/MTHI/MTLO
// service and a stall toward the hazard unit while a result is pending.
module alu_muldiv #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
    input  logic              d_clk,
    input  logic              d_rst,
    input  logic              m_i_valid,
    input  logic [4:0]        m_i_funct,
    input  logic [DWIDTH-1:0] m_i_data_rs,
    input  logic [DWIDTH-1:0] m_i_data_rt,
    input  logic              m_i_flush,
    output logic [DWIDTH-1:0] m_o_value,
    output logic              m_o_busy,
    output logic              m_o_stall,
    output logic              m_o_done,
    output logic              m_o_div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [4:0] F_MFHI = 5'd24;
    localparam logic [4:0] F_MFLO = 5'd25;
    localparam logic [4:0] F_MTHI = 5'd26;
    localparam logic [4:0] F_MTLO = 5'd27;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DWIDTH-1:0]   hi, lo;
    logic [DWIDTH-1:0]   opnd_b;
    logic [DWIDTH-1:0]   dividend;
    logic [2*DWIDTH-1:0] acc;
    logic                is_div, neg_q, neg_r, div_zero;

    logic                is_md, is_any, start, sign_op, a_neg, b_neg;
    logic [DWIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        is_md   = (m_i_funct >= 5'd20) && (m_i_funct <= 5'd23);
        is_any  = (m_i_funct >= 5'd20) && (m_i_funct <= 5'd27);
        start   = m_i_valid && is_md && (state == IDLE) && !m_i_flush;
        sign_op = is_md && !m_i_funct[0];
        a_neg   = sign_op && m_i_data_rs[DWIDTH-1];
        b_neg   = sign_op && m_i_data_rt[DWIDTH-1];
        a_mag   = a_neg ? -m_i_data_rs : m_i_data_rs;
        b_mag   = b_neg ? -m_i_data_rt : m_i_data_rt;
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    logic [DWIDTH:0]     mul_sum, div_diff;
    logic [2*DWIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opnd_b} : {(DWIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[DWIDTH-1:1]};
        div_diff = acc[2*DWIDTH-1:DWIDTH-1] - {1'b0, opnd_b};
        div_next = div_diff[DWIDTH] ? {acc[2*DWIDTH-2:0], 1'b0}
                                    : {div_diff[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b1};
    end

    logic [2*DWIDTH-1:0] prod_fix;
    logic [DWIDTH-1:0]   res_hi, res_lo;
    logic                b_zero;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        b_zero   = (opnd_b == '0);
        res_hi   = prod_fix[2*DWIDTH-1:DWIDTH];
        res_lo   = prod_fix[DWIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = dividend;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc[2*DWIDTH-1:DWIDTH] : acc[2*DWIDTH-1:DWIDTH];
                res_lo = neg_q ? -acc[DWIDTH-1:0] : acc[DWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd_b   <= '0;
            dividend <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CALC;
                        cnt      <= CNT_W'(DWIDTH);
                        acc      <= {{DWIDTH{1'b0}}, a_mag};
                        opnd_b   <= b_mag;
                        dividend <= m_i_data_rs;
                        is_div   <= m_i_funct[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                    end else if (m_i_valid && !m_i_flush && m_i_funct == F_MTHI) begin
                        hi <= m_i_data_rs;
                    end else if (m_i_valid && !m_i_flush && m_i_funct == F_MTLO) begin
                        lo <= m_i_data_rs;
                    end
                end
                CALC: begin
                    if (m_i_flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!m_i_flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                        if (is_div)
                            div_zero <= b_zero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_o_busy  = (state != IDLE);
        m_o_done  = (state == FIN) && !m_i_flush;
        m_o_stall = m_i_valid && is_any && m_o_busy;
        m_o_value = '0;
        if (m_i_valid && !m_o_busy) begin
            if (m_i_funct == F_MFHI)
                m_o_value = hi;
            else if (m_i_funct == F_MFLO)
                m_o_value = lo;
        end
    end

    assign m_o_div_zero = div_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: vector table for mul/div results plus hand-written
// sequences for stall, back-to-back start, flush, async reset and a 16-bit instance.
module tb_alu_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid, flush;
    logic [4:0]  funct;
    logic [31:0] rs, rt;
    logic [31:0] value;
    logic        busy, stall, done, dz;

    logic        v16, fl16;
    logic [4:0]  f16;
    logic [15:0] rs16, rt16, value16;
    logic        busy16, stall16, done16, dz16;

    alu_muldiv #(.DWIDTH(32)) dut (
        .d_clk(clk), .d_rst(rst_n), .m_i_valid(valid), .m_i_funct(funct),
        .m_i_data_rs(rs), .m_i_data_rt(rt), .m_i_flush(flush),
        .m_o_value(value), .m_o_busy(busy), .m_o_stall(stall),
        .m_o_done(done), .m_o_div_zero(dz)
    );

    alu_muldiv #(.DWIDTH(16)) dut16 (
        .d_clk(clk), .d_rst(rst_n), .m_i_valid(v16), .m_i_funct(f16),
        .m_i_data_rs(rs16), .m_i_data_rt(rt16), .m_i_flush(fl16),
        .m_o_value(value16), .m_o_busy(busy16), .m_o_stall(stall16),
        .m_o_done(done16), .m_o_div_zero(dz16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a, b;
        logic [31:0] hi, lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1; funct = f; rs = a; rt = b;
        @(posedge clk);
        #1 valid = 1'b0; funct = 5'd0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        valid = 1'b1; funct = 5'd24;
        #1 h = value;
        funct = 5'd25;
        #1 l = value;
        valid = 1'b0; funct = 5'd0;
    endtask

    initial begin
        int          lat, sc, nd;
        logic [31:0] h, l;

        vecs[0] = '{5'd20, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{5'd21, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{5'd23, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4] = '{5'd22, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[5] = '{5'd23, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
        vecs[6] = '{5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[7] = '{5'd20, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
        vecs[8] = '{5'd22, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[9] = '{5'd22, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; funct = 5'd0; rs = '0; rt = '0;
        v16 = 1'b0; fl16 = 1'b0; f16 = 5'd0; rs16 = '0; rt16 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_value", value, 0);
        rst_n = 1'b1;
        read_hilo(h, l);
        check("rst_hi", h, 0);
        check("rst_lo", l, 0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), lat, 33);
            read_hilo(h, l);
            check($sformatf("v%0d_hi", i), h, vecs[i].hi);
            check($sformatf("v%0d_lo", i), l, vecs[i].lo);
            check($sformatf("v%0d_dz", i), dz, vecs[i].dz);
        end

        // MTHI then MFHI next cycle; LO keeps the last divide's value
        @(negedge clk);
        valid = 1'b1; funct = 5'd26; rs = 32'hA5A5A5A5;
        @(negedge clk);
        funct = 5'd24;
        #1 check("mthi_hi", value, 32'hA5A5A5A5);
        funct = 5'd25;
        #1 check("mthi_lo", value, 32'hFFFFFFFF);
        valid = 1'b0; funct = 5'd0;

        // MFLO three cycles after a MULT start is held until the result lands
        issue(5'd20, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        valid = 1'b1; funct = 5'd25;
        #1;
        sc = -1;
        for (int k = 3; k <= 100; k++) begin
            if (!stall) begin
                sc = k;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("mflo_stall_cyc", sc, 34);
        check("mflo_value", value, 32'd15);
        valid = 1'b0; funct = 5'd0;

        // A new MULT presented during FIN waits one cycle, then starts
        issue(5'd20, 32'd2, 32'd3);
        wait_done(lat);
        check("b2b_lat1", lat, 33);
        valid = 1'b1; funct = 5'd20; rs = 32'd4; rt = 32'd5;
        #1 check("b2b_stall_fin", stall, 1);
        @(negedge clk);
        check("b2b_stall_idle", stall, 0);
        check("b2b_busy_idle", busy, 0);
        @(posedge clk);
        #1 valid = 1'b0; funct = 5'd0;
        wait_done(lat);
        check("b2b_lat2", lat, 33);
        read_hilo(h, l);
        check("b2b_hi", h, 0);
        check("b2b_lo", l, 32'd20);

        // Flush mid-divide leaves HI/LO and the sticky flag alone
        @(negedge clk);
        valid = 1'b1; funct = 5'd26; rs = 32'h11111111;
        @(negedge clk);
        funct = 5'd27; rs = 32'h22222222;
        @(negedge clk);
        valid = 1'b0; funct = 5'd0;
        check("pre_flush_dz", dz, 1);
        issue(5'd22, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", nd, 0);
        read_hilo(h, l);
        check("flush_hi", h, 32'h11111111);
        check("flush_lo", l, 32'h22222222);
        check("flush_dz", dz, 1);

        // Flush wins over a start in IDLE
        @(negedge clk);
        valid = 1'b1; funct = 5'd20; rs = 32'd3; rt = 32'd3; flush = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0; funct = 5'd0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", busy, 0);

        // Asynchronous reset in the middle of CALC
        issue(5'd20, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dz", dz, 0);
        valid = 1'b1; funct = 5'd24;
        #1 check("arst_hi", value, 0);
        funct = 5'd25;
        #1 check("arst_lo", value, 0);
        valid = 1'b0; funct = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // 16-bit instance: signed most-negative squared
        @(negedge clk);
        v16 = 1'b1; f16 = 5'd20; rs16 = 16'h8000; rt16 = 16'h8000;
        @(posedge clk);
        #1 v16 = 1'b0; f16 = 5'd0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done16) begin
                lat = c;
                break;
            end
        end
        check("w16_lat", lat, 17);
        @(negedge clk);
        v16 = 1'b1; f16 = 5'd24;
        #1 check("w16_hi", {16'd0, value16}, 32'h4000);
        f16 = 5'd25;
        #1 check("w16_lo", {16'd0, value16}, 32'h0000);
        v16 = 1'b0; f16 = 5'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
